reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 70 +++++++
 tb/tb_reg_file_sb.sv | 129 ++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/2W register file with a per-register busy scoreboard,
// optional write-to-read forwarding and a registered debug window.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int DBG_BASE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              BSY1,
  output logic              BSY2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD,
  input  logic              wr,
  input  logic [ADDR_W-1:0] A4,
  input  logic [DATA_W-1:0] WD4,
  input  logic              wr4,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wr_conflict
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic              w_we0, w_we1, w_set, w_clr1, w_clr2, w_set1, w_set2;
  logic [ADDR_W-1:0] w_dbg_idx;
  logic [DATA_W-1:0] w_dbg_nxt;
  assign w_we0     = wr && A3 != '0;
  assign w_we1     = wr4 && A4 != '0;
  assign w_set     = set_en && set_addr != '0;
  assign w_dbg_idx = ADDR_W'(DBG_BASE + int'(dbg_sel));
  assign w_dbg_nxt = (w_we1 && A4 == w_dbg_idx) ? WD4 :
                     (w_we0 && A3 == w_dbg_idx) ? WD : r_mem[w_dbg_idx];
  // Reads are gated by rst_n so forwarded write data cannot leak out during reset
  assign RD1 = !rst_n ? '0 :
               (BYPASS != 0 && w_we1 && A4 == A1) ? WD4 :
               (BYPASS != 0 && w_we0 && A3 == A1) ? WD : r_mem[A1];
  assign RD2 = !rst_n ? '0 :
               (BYPASS != 0 && w_we1 && A4 == A2) ? WD4 :
               (BYPASS != 0 && w_we0 && A3 == A2) ? WD : r_mem[A2];
  assign w_clr1 = (w_we0 && A3 == A1) || (w_we1 && A4 == A1);
  assign w_clr2 = (w_we0 && A3 == A2) || (w_we1 && A4 == A2);
  assign w_set1 = w_set && set_addr == A1;
  assign w_set2 = w_set && set_addr == A2;
  assign BSY1 = r_busy[A1] && !(BYPASS != 0 && w_clr1 && !w_set1);
  assign BSY2 = r_busy[A2] && !(BYPASS != 0 && w_clr2 && !w_set2);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy      <= '0;
      dbg_data    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (w_we0) r_mem[A3] <= WD;
      if (w_we1) r_mem[A4] <= WD4;
      if (w_we0) r_busy[A3] <= 1'b0;
      if (w_we1) r_busy[A4] <= 1'b0;
      if (w_set) r_busy[set_addr] <= 1'b1;
      dbg_data    <= w_dbg_nxt;
      wr_conflict <= w_we0 && w_we1 && A3 == A4;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks of reg_file_sb with forwarding on (u_byp) and off (u_nob).
module tb_reg_file_sb;
  logic        clk = 0, rst_n = 1;
  logic [4:0]  A1 = 0, A2 = 0, A3 = 0, A4 = 0, set_addr = 0;
  logic [31:0] WD = 0, WD4 = 0;
  logic        wr = 0, wr4 = 0, set_en = 0;
  logic [2:0]  dbg_sel = 0;
  logic [31:0] b_rd1, b_rd2, b_dbg, n_rd1, n_rd2, n_dbg;
  logic        b_bsy1, b_bsy2, b_cf, n_bsy1, n_bsy2, n_cf;
  int tests = 0, fails = 0;

  reg_file_sb #(.BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .RD1(b_rd1), .RD2(b_rd2),
    .BSY1(b_bsy1), .BSY2(b_bsy2), .A3(A3), .WD(WD), .wr(wr), .A4(A4), .WD4(WD4),
    .wr4(wr4), .set_en(set_en), .set_addr(set_addr), .dbg_sel(dbg_sel),
    .dbg_data(b_dbg), .wr_conflict(b_cf));
  reg_file_sb #(.BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .RD1(n_rd1), .RD2(n_rd2),
    .BSY1(n_bsy1), .BSY2(n_bsy2), .A3(A3), .WD(WD), .wr(wr), .A4(A4), .WD4(WD4),
    .wr4(wr4), .set_en(set_en), .set_addr(set_addr), .dbg_sel(dbg_sel),
    .dbg_data(n_dbg), .wr_conflict(n_cf));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst_n = 0;
    tick(); tick();
    #2 rst_n = 1;
    tick();
    A1 = 5; A2 = 0; #1;
    chk("rst_rd1", b_rd1, 0);
    chk("rst_rd2", b_rd2, 0);
    chk("rst_bsy1", {31'b0, b_bsy1}, 0);
    chk("rst_dbg", b_dbg, 0);
    chk("rst_cf", {31'b0, b_cf}, 0);
    wr = 1; A3 = 7; WD = 32'hDEADBEEF; A1 = 7; #1;
    chk("byp_rd1_same", b_rd1, 32'hDEADBEEF);
    chk("nob_rd1_same", n_rd1, 0);
    tick();
    wr = 0; #1;
    chk("byp_rd1_after", b_rd1, 32'hDEADBEEF);
    chk("nob_rd1_after", n_rd1, 32'hDEADBEEF);
    wr = 1; A3 = 9; WD = 32'h11; wr4 = 1; A4 = 9; WD4 = 32'h22; A1 = 9; #1;
    chk("byp_prio", b_rd1, 32'h22);
    chk("cf_before", {31'b0, b_cf}, 0);
    tick();
    wr = 0; wr4 = 0; #1;
    chk("mem9", n_rd1, 32'h22);
    chk("cf_pulse", {31'b0, n_cf}, 1);
    tick();
    chk("cf_drop", {31'b0, n_cf}, 0);
    wr = 1; wr4 = 1; A3 = 0; A4 = 0; WD = 32'h33; WD4 = 32'h44; A1 = 0; #1;
    chk("byp_rd0", b_rd1, 0);
    tick();
    wr = 0; wr4 = 0; #1;
    chk("cf_zero", {31'b0, b_cf}, 0);
    chk("mem0", n_rd1, 0);
    set_en = 1; set_addr = 12; A1 = 12; A2 = 12; #1;
    chk("bsy_pre_set", {31'b0, b_bsy1}, 0);
    tick();
    set_en = 0; #1;
    chk("bsy_set", {31'b0, b_bsy1}, 1);
    chk("bsy2_set", {31'b0, n_bsy2}, 1);
    wr = 1; A3 = 12; WD = 5; set_en = 1; set_addr = 12; #1;
    chk("byp_bsy_setwins", {31'b0, b_bsy1}, 1);
    tick();
    wr = 0; set_en = 0; #1;
    chk("bsy_setwins_b", {31'b0, b_bsy1}, 1);
    chk("bsy_setwins_n", {31'b0, n_bsy1}, 1);
    wr = 1; A3 = 12; WD = 6; #1;
    chk("byp_bsy_fwdclr", {31'b0, b_bsy1}, 0);
    chk("nob_bsy_stored", {31'b0, n_bsy1}, 1);
    chk("byp_bsy2_fwdclr", {31'b0, b_bsy2}, 0);
    tick();
    wr = 0; #1;
    chk("bsy_clr_b", {31'b0, b_bsy1}, 0);
    chk("bsy_clr_n", {31'b0, n_bsy1}, 0);
    chk("rd12", n_rd1, 6);
    wr = 1; A3 = 18; WD = 32'h55; dbg_sel = 2; #1;
    chk("dbg_pre", b_dbg, 0);
    tick();
    wr = 0; #1;
    chk("dbg_18", b_dbg, 32'h55);
    chk("dbg_18_n", n_dbg, 32'h55);
    dbg_sel = 0;
    tick();
    chk("dbg_16", b_dbg, 0);
    dbg_sel = 2;
    set_en = 1; set_addr = 0; A1 = 0; #1;
    chk("bsy0_same", {31'b0, b_bsy1}, 0);
    tick();
    set_en = 0; #1;
    chk("bsy0_after", {31'b0, b_bsy1}, 0);
    wr = 1; A3 = 3; WD = 32'hAA; set_en = 1; set_addr = 4;
    tick();
    wr = 0; set_en = 0; A1 = 3; A2 = 4; #1;
    chk("pre_rst_rd", n_rd1, 32'hAA);
    chk("pre_rst_bsy", {31'b0, n_bsy2}, 1);
    chk("pre_rst_dbg", n_dbg, 32'h55);
    #1 wr = 1; A3 = 3; WD = 32'h77; set_en = 1; set_addr = 3;
    rst_n = 0; #1;
    chk("rst_async_rd_b", b_rd1, 0);
    chk("rst_async_rd_n", n_rd1, 0);
    chk("rst_async_bsy", {31'b0, n_bsy2}, 0);
    chk("rst_async_dbg", b_dbg, 0);
    tick();
    chk("rst_hold_rd", n_rd1, 0);
    #2 rst_n = 1; wr = 0; set_en = 0; A2 = 18;
    tick();
    chk("post_rst_rd1", n_rd1, 0);
    chk("post_rst_rd2", n_rd2, 0);
    chk("post_rst_bsy", {31'b0, n_bsy1}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
